booth_multiplicador_seq: RTL
============================

Name: booth_multiplicador_seq

Overview:
- Sequential radix-2 Booth multiplier for two signed two's-complement operands taken from the board switches.
- Produces a full-width signed product, which the display chain then converts to decimal digits for the 7-segment driver.
- Sits directly upstream of the binary-to-decimal digit decoder.
- Uses one clock domain shared with the display logic. Runs one Booth step per clock, with start/busy/done control.

Parameters:
- WIDTH, 8, operand width in bits (signed); product is 2*WIDTH bits. Legal values 2..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  request a multiplication; honoured only in IDLE
- multiplicando  input  WIDTH  signed multiplicand M, sampled on the accepting edge
- multiplicador  input  WIDTH  signed multiplier Q, sampled on the accepting edge
- producto  output  2*WIDTH  signed product M*Q, registered; holds the last result
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when producto is updated

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; producto=0; busy=0; done=0; internal A, Q, q_1 and counter cleared.
  - Reset has priority over every other input. It aborts an operation in flight with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on an edge with start=1. On that edge:
    - M_ext <= multiplicando sign-extended to WIDTH+1 bits
    - A <= 0 (WIDTH+1 bits)
    - Q <= multiplicador
    - q_1 <= 0
    - cnt <= WIDTH
    - busy <= 1
  - RUN: each edge performs one Booth step, then cnt <= cnt-1.
  - RUN -> IDLE on the edge where cnt==1 (the final step).
- Booth step, on the pair {Q[0], q_1}:
  - 01: A <= A + M_ext
  - 10: A <= A - M_ext
  - 00/11: A unchanged
  - Then arithmetic right shift of {A, Q, q_1} by one, with the MSB of A replicated.
  - The A adder is WIDTH+1 bits, so no overflow, including M = -2^(WIDTH-1).
- Completion, on the final-step edge:
  - producto <= the low 2*WIDTH bits of the shifted {A, Q}.
  - done <= 1 for exactly one cycle.
  - busy <= 0.
- Latency:
  - start accepted at edge k -> producto valid and done=1 after edge k+WIDTH.
  - busy is high after edges k .. k+WIDTH-1.
  - Throughput is one result per WIDTH+1 cycles (the next start can be accepted at edge k+WIDTH+1).
- Boundary conditions:
  - start while busy: ignored; the operation in flight is unaffected.
  - start held high continuously: a new operation begins on each return to IDLE.
  - start=1 in the cycle done=1: accepted (the FSM is in IDLE).
  - Operand changes after the accepting edge have no effect.
  - producto is not cleared at start. It keeps the previous result until the new one completes, so the display never shows partial values.
  - Operand 0 gives producto=0 with the same latency; there is no early termination.
- Arithmetic: the result is exact for all operand pairs. Range -2^(2W-2)+2^(W-1) .. 2^(2W-2).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, with start=1 and random operands -> producto=0x0000, busy=0, done=0 throughout; no operation starts after release until a new start edge.
- Basic positive (WIDTH=8): M=3, Q=5, start pulse at edge k:
  - busy high for edges k..k+7.
  - done pulse after edge k+8.
  - producto=0x000F. A second identical start gives the same result and latency.
- Mixed and extreme signs, each a separate run:
  - M=-7 (0xF9), Q=6 -> producto=0xFFD6 (-42)
  - M=-128, Q=-128 -> 0x4000 (16384)
  - M=127, Q=-128 -> 0xC080 (-16256)
  - M=-128, Q=127 -> 0xC080
  - M=0, Q=-1 -> 0x0000
- Start during busy: start M=2, Q=3; 3 cycles later pulse start with M=10, Q=10 -> ignored; producto=0x0006 after 8 steps; the second request is never computed.
- Back-to-back: hold start=1 with M=-1, Q=-1 -> done pulses every 9 cycles, producto=0x0001 each time, busy low for exactly one cycle between runs.
- Reset mid-operation: start M=5, Q=5, assert rst_n=0 at step 4 -> no done pulse; producto=0; after release, start M=5, Q=5 -> 0x0019 after full latency.
- Randomised sweep: at least 1000 random signed pairs, compared against a reference signed product.

Source files
------------

// File: rtl/booth_multiplicador_seq.sv
// Sequential radix-2 Booth multiplier for two signed two's-complement
// operands. One Booth step per clock, with start/busy/done handshake.
// The product register holds the last completed result, so the downstream
// binary-to-decimal decoder never sees a partial value.
//
// Datapath per step: {A, Q, q_1}, where A is WIDTH+1 bits wide. The extra
// bit keeps A +/- M_ext exact even for M = -2^(WIDTH-1).
// The caller sets WIDTH to a value in 2..16.
module booth_multiplicador_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicando,
   input  logic [WIDTH-1:0]     multiplicador,
   output logic [2*WIDTH-1:0]   producto,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state;
   logic [WIDTH:0]     m_ext;     // sign-extended multiplicand
   logic [WIDTH:0]     acc;       // A register
   logic [WIDTH-1:0]   q_reg;     // multiplier / low half of the product
   logic               q_1;       // Booth history bit
   logic [CNT_W-1:0]   cnt;       // steps remaining

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     acc_next;
   logic [WIDTH-1:0]   q_next;
   logic               q_1_next;
   logic [2*WIDTH-1:0] prod_next;
   logic               last_step;

   assign last_step = (cnt == CNT_W'(1));

   // One Booth step: add/subtract M on the {Q[0], q_1} pair, then an
   // arithmetic right shift of {A, Q, q_1}.
   always_comb begin
      // NOTE: every output of this block gets a default before the case, so
      // no path leaves a variable unassigned and no latch is inferred.
      sum = acc;
      case ({q_reg[0], q_1})
         2'b01:   sum = acc + m_ext;
         2'b10:   sum = acc - m_ext;
         default: sum = acc;
      endcase

      acc_next = {sum[WIDTH], sum[WIDTH:1]};
      q_next   = {sum[0], q_reg[WIDTH-1:1]};
      q_1_next = q_reg[0];

      // Low 2*WIDTH bits of the shifted {A, Q}: the replicated sign bit
      // drops off the top, leaving the whole sum above the shifted Q.
      prod_next = {sum, q_reg[WIDTH-1:1]};
   end

   // Control FSM and datapath registers; reset is synchronous and wins over
   // everything, aborting any operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the values from before this edge, whatever the
      // statement order.
      if (!rst_n) begin
         state    <= IDLE;
         m_ext    <= '0;
         acc      <= '0;
         q_reg    <= '0;
         q_1      <= 1'b0;
         cnt      <= '0;
         producto <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  m_ext <= {multiplicando[WIDTH-1], multiplicando};
                  acc   <= '0;
                  q_reg <= multiplicador;
                  q_1   <= 1'b0;
                  cnt   <= CNT_W'(WIDTH);
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               acc   <= acc_next;
               q_reg <= q_next;
               q_1   <= q_1_next;
               cnt   <= cnt - CNT_W'(1);
               if (last_step) begin
                  // Product and done change together; busy drops so the
                  // next start is taken on the following edge.
                  state    <= IDLE;
                  producto <= prod_next;
                  done     <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
